// File: rtl/frame_mean_binarize_pkg.sv
// Shared types and constants for the frame-mean binarizer: gray range, output pixel codes,
// divider state encoding and the RGB444-to-gray weighting.
package frame_mean_binarize_pkg;

    localparam int GRAY_W = 6;
    localparam logic [GRAY_W-1:0] GRAY_MAX = 6'd60;

    localparam logic [11:0] WHITE_PIX = 12'hFFF;
    localparam logic [11:0] BLACK_PIX = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_LOAD = 2'd2
    } div_state_e;

    // Luma approximation R + 2G + B; tops out at 15 + 30 + 15 = 60, so 6 bits never overflow
    function automatic logic [GRAY_W-1:0] rgb444_to_gray(input logic [11:0] pix);
        return {2'b00, pix[11:8]} + {1'b0, pix[7:4], 1'b0} + {2'b00, pix[3:0]};
    endfunction

endpackage

// File: rtl/frame_mean_binarize_serial_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle, followed by a one-cycle
// LOAD state during which done is high.
module serial_divider
    import frame_mean_binarize_pkg::*;
#(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     num_r;
    logic [W-1:0]     rem_r;
    logic [W-1:0]     quot_r;
    logic             done_r;

    logic [W:0]       trial_s;
    logic [W:0]       diff_s;
    logic [W-1:0]     rem_next_s;
    logic             q_bit_s;

    // One restoring step: shift in the next dividend bit and subtract if it fits
    always_comb begin
        trial_s = {rem_r, num_r[W-1]};
        diff_s  = trial_s - {1'b0, divisor};
        if (trial_s >= {1'b0, divisor}) begin
            rem_next_s = diff_s[W-1:0];
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = trial_s[W-1:0];
            q_bit_s    = 1'b0;
        end
    end

    // Divider sequencer: IDLE -> DIV (W steps) -> LOAD -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            num_r   <= '0;
            rem_r   <= '0;
            quot_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_DIV;
                        num_r   <= dividend;
                        rem_r   <= '0;
                        quot_r  <= '0;
                        cnt_r   <= '0;
                    end
                end
                ST_DIV: begin
                    num_r  <= {num_r[W-2:0], 1'b0};
                    rem_r  <= rem_next_s;
                    quot_r <= {quot_r[W-2:0], q_bit_s};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_LOAD;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;
    assign quotient = quot_r;

endmodule

// File: rtl/frame_mean_binarize.sv
// Binarizes RGB444 pixels against the mean gray of the previous frame.
// Define BINARIZE_INVERT_EN to emit white for dark pixels instead of bright ones.
module frame_mean_binarize
    import frame_mean_binarize_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int INIT_THRESH = 30,
    parameter int SUM_W       = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_enable,
    input  logic [11:0]       in_data,
    output logic              out_ready,
    output logic [11:0]       out_data,
    output logic              frame_done,
    output logic [GRAY_W-1:0] thresh
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [SUM_W-1:0] PIX_COUNT = SUM_W'(IMG_W * IMG_H);
    localparam logic [SUM_W-1:0] SAT_LIMIT = {{(SUM_W-GRAY_W){1'b0}}, GRAY_MAX};

    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic              valid_r;
    logic              last_r;
    logic [GRAY_W-1:0] gray_r;
    logic [SUM_W-1:0]  sum_r;
    logic [GRAY_W-1:0] thresh_r;
    logic              out_ready_r;
    logic [11:0]       out_data_r;
    logic              frame_done_r;

    logic              last_pix_s;
    logic [SUM_W-1:0]  gray_ext_s;
    logic [SUM_W-1:0]  dividend_s;
    logic              div_start_s;
    logic              div_busy_s;
    logic              div_done_s;
    logic [SUM_W-1:0]  div_quot_s;
    logic [GRAY_W-1:0] new_thresh_s;
    logic [11:0]       pix_s;

    assign last_pix_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
    assign gray_ext_s = {{(SUM_W-GRAY_W){1'b0}}, gray_r};

    // Raster position of the incoming pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (in_enable) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
            end else begin
                col_r <= col_r + 1'b1;
            end
        end
    end

    // Stage 1: gray conversion, tagged with valid and end-of-frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            gray_r  <= '0;
        end else begin
            valid_r <= in_enable;
            if (in_enable) begin
                last_r <= last_pix_s;
                gray_r <= rgb444_to_gray(in_data);
            end
        end
    end

    // Frame sum; the final pixel goes straight into the dividend so the next frame starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= '0;
        end else if (valid_r) begin
            sum_r <= last_r ? '0 : sum_r + gray_ext_s;
        end
    end

    assign dividend_s  = sum_r + gray_ext_s;
    // A frame ending while the divider is still busy simply loses its mean
    assign div_start_s = valid_r && last_r && !div_busy_s;

    serial_divider #(
        .W (SUM_W)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (PIX_COUNT),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Quotient clamp and output polarity
    always_comb begin
        new_thresh_s = GRAY_MAX;
        if (div_quot_s > SAT_LIMIT) begin
            new_thresh_s = GRAY_MAX;
        end else begin
            new_thresh_s = div_quot_s[GRAY_W-1:0];
        end
        pix_s = BLACK_PIX;
`ifdef BINARIZE_INVERT_EN
        if (gray_r > thresh_r) begin
            pix_s = BLACK_PIX;
        end else begin
            pix_s = WHITE_PIX;
        end
`else
        if (gray_r > thresh_r) begin
            pix_s = WHITE_PIX;
        end else begin
            pix_s = BLACK_PIX;
        end
`endif
    end

    // Threshold update and stage 2 compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_r     <= GRAY_W'(INIT_THRESH);
            frame_done_r <= 1'b0;
            out_ready_r  <= 1'b0;
            out_data_r   <= BLACK_PIX;
        end else begin
            frame_done_r <= div_done_s;
            if (div_done_s) begin
                thresh_r <= new_thresh_s;
            end
            out_ready_r <= valid_r;
            if (valid_r) begin
                out_data_r <= pix_s;
            end
        end
    end

    assign out_ready  = out_ready_r;
    assign out_data   = out_data_r;
    assign frame_done = frame_done_r;
    assign thresh     = thresh_r;

endmodule

// File: doc/frame_mean_binarize.md
Name: frame_mean_binarize

Overview:
- Downstream consumer of the mean-filter stage output (12-bit RGB444 pixel plus in_enable strobe).
- Converts each smoothed pixel to a 6-bit gray level and binarizes it against an adaptive threshold.
- The threshold is the mean gray of the previous complete frame, computed by a serial divider during the inter-frame gap.
- Output is a black/white 12-bit pixel stream feeding the plate-segmentation stages.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- INIT_THRESH, 30, threshold used after reset until the first frame completes (6-bit, 0..60).
- SUM_W, 25, accumulator width; must hold 60*IMG_W*IMG_H.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in_enable  input  1  in_data valid this cycle.
- in_data  input  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}.
- out_ready  output  1  out_data valid this cycle.
- out_data  output  12  12'hFFF (white) or 12'h000 (black).
- frame_done  output  1  one-cycle pulse when the new threshold is loaded.
- thresh  output  6  threshold currently applied.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values: out_ready=0, out_data=0, frame_done=0, thresh=INIT_THRESH. Counters, accumulator and divider are cleared; divider state is IDLE.
- Pipeline stage 1, on in_enable: gray = R + 2*G + B, 6-bit unsigned with range 0..60, registered with a valid bit.
- Pipeline stage 2: out_data = (gray > thresh) ? 12'hFFF : 12'h000, and out_ready = stage-1 valid.
- Latency is exactly 2 cycles from in_enable to out_ready. There is no backpressure and no bubbles are inserted.
- Gaps in in_enable propagate as out_ready=0. out_data holds its last value while out_ready=0.
- Position counters:
  - col increments 0..IMG_W-1 on each in_enable.
  - At wrap, row increments 0..IMG_H-1.
  - The last pixel is col=IMG_W-1 and row=IMG_H-1; both counters then wrap to 0.
- Accumulator: sum += gray on each stage-1 valid.
  - On the last pixel, sum+gray is latched into the divider dividend and the accumulator restarts at 0.
  - The first pixel of the next frame is accumulated normally in the following cycle.
- Divider FSM:
  - IDLE -> DIV when the last pixel is latched.
  - DIV is a restoring division by IMG_W*IMG_H, one quotient bit per cycle, SUM_W cycles.
  - DIV -> LOAD: thresh <= quotient (saturated to 60), frame_done=1 for one cycle.
  - LOAD -> IDLE.
- Pixels arriving during DIV or LOAD are compared against the old thresh. The new thresh applies from the cycle after LOAD.
- If a frame ends while the FSM is not IDLE (frame shorter than SUM_W+2 pixels), the new dividend is dropped and the counters and accumulator still restart.
- Reset mid-frame or mid-division aborts everything; thresh returns to INIT_THRESH.
- Arithmetic is unsigned throughout. Comparison is strict greater-than, so gray == thresh maps to black.

Optional Feature:
- Macro BINARIZE_INVERT_EN.
- When defined: out_data = (gray > thresh) ? 12'h000 : 12'hFFF, giving dark characters as white foreground for the segmentation stage.
- When undefined: polarity is as in Behaviour.
- Threshold computation is unaffected either way.

Decomposition:
- Shared package holds:
  - GRAY_W=6 and GRAY_MAX=60.
  - WHITE_PIX=12'hFFF and BLACK_PIX=12'h000.
  - The divider state enum (IDLE, DIV, LOAD).
- One natural sub-module, serial_divider: start/dividend/divisor in, busy/done/quotient out, one bit per cycle. The top-level holds the counters, accumulator, gray pipeline and compare.

Test Plan:
- Bench uses IMG_W=4, IMG_H=4, SUM_W=10, INIT_THRESH=30.
- Reset, then a single in_enable with in_data=12'h888 (gray 32) -> out_ready high exactly 2 cycles later, out_data=12'hFFF, thresh=30.
- Pixel 12'h777 (gray 28) and pixel 12'h000 -> both 12'h000. A gray value equal to thresh (R=6,G=6,B=6 => 24 with thresh forced to 24 by a prior frame) -> 12'h000.
- 16 pixels, 8 of gray 60 (12'hFFF) and 8 of gray 0 -> frame_done pulses SUM_W+1 cycles after the last pixel, thresh=30. Then 16 pixels all 12'h444 (gray 16) -> thresh becomes 16 and frame_done pulses again.
- A frame of 12'h444 immediately followed, with no gap, by a frame of 12'hFFF -> pixels during DIV use the old thresh. The second frame yields thresh=60, and a following 12'hFFF pixel outputs black because 60 > 60 is false.
- Assert rst mid-division -> outputs and thresh return to reset values in the same cycle. The next full frame recomputes correctly.
- With BINARIZE_INVERT_EN defined, repeat the first scenario -> out_data=12'h000.
